// File: rtl/unique_case_mux.sv
// Registered 4:1 selector with a unique-case decode, per-source saturating
// capture counters and a select-change strobe for debug visibility.
module unique_case_mux #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic [1:0]        sel_in,
    input  logic              en_in,
    input  logic              cnt_clr_in,
    output logic [DATA_W-1:0] y_out,
    output logic [1:0]        sel_q_out,
    output logic              sel_chg_out,
    output logic [CNT_W-1:0]  cnt_a_out,
    output logic [CNT_W-1:0]  cnt_b_out,
    output logic [CNT_W-1:0]  cnt_c_out,
    output logic [CNT_W-1:0]  cnt_d_out
);

    localparam int unsigned NUM_SRC = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mux_c;
    logic [CNT_W-1:0]  cnt_q [NUM_SRC];

    // Source decode; all four select codes are covered
    always_comb begin
        mux_c = '0;
        unique case (sel_in)
            2'b00: mux_c = a_in;
            2'b01: mux_c = b_in;
            2'b10: mux_c = c_in;
            2'b11: mux_c = d_in;
        endcase
    end

    // Output, select history and strobe registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_out       <= '0;
            sel_q_out   <= 2'b00;
            sel_chg_out <= 1'b0;
        end else begin
            sel_chg_out <= en_in && (sel_in != sel_q_out);
            if (en_in) begin
                y_out     <= mux_c;
                sel_q_out <= sel_in;
            end
        end
    end

    // Saturating per-source counters; clear wins over increment
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else if (cnt_clr_in) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else if (en_in && (cnt_q[sel_in] != CNT_MAX)) begin
            cnt_q[sel_in] <= cnt_q[sel_in] + CNT_W'(1);
        end
    end

    assign cnt_a_out = cnt_q[0];
    assign cnt_b_out = cnt_q[1];
    assign cnt_c_out = cnt_q[2];
    assign cnt_d_out = cnt_q[3];

endmodule

// File: tb/tb_unique_case_mux.sv
// Directed bench for unique_case_mux: an 8-bit-counter instance for the main
// function and a 2-bit-counter instance sharing the same stimulus for saturation.
module tb_unique_case_mux;

    logic       clk;
    logic       rst_n;
    logic       a, b, c, d;
    logic [1:0] sel;
    logic       en;
    logic       cnt_clr;

    logic       y1, y2;
    logic [1:0] sel_q1, sel_q2;
    logic       chg1, chg2;
    logic [7:0] ca1, cb1, cc1, cd1;
    logic [1:0] ca2, cb2, cc2, cd2;

    int checks = 0;
    int errors = 0;

    unique_case_mux #(.DATA_W(1), .CNT_W(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_in(a), .b_in(b), .c_in(c), .d_in(d),
        .sel_in(sel), .en_in(en), .cnt_clr_in(cnt_clr),
        .y_out(y1), .sel_q_out(sel_q1), .sel_chg_out(chg1),
        .cnt_a_out(ca1), .cnt_b_out(cb1), .cnt_c_out(cc1), .cnt_d_out(cd1)
    );

    unique_case_mux #(.DATA_W(1), .CNT_W(2)) dut_sat (
        .clk_in(clk), .rst_n_in(rst_n),
        .a_in(a), .b_in(b), .c_in(c), .d_in(d),
        .sel_in(sel), .en_in(en), .cnt_clr_in(cnt_clr),
        .y_out(y2), .sel_q_out(sel_q2), .sel_chg_out(chg2),
        .cnt_a_out(ca2), .cnt_b_out(cb2), .cnt_c_out(cc2), .cnt_d_out(cd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] r;
    logic       exp_y;
    logic [1:0] exp_selq;
    int         exp_cnt [4];
    int         sum;
    logic [3:0] abcd;
    logic [1:0] sel_seq [4];
    logic       y_seq   [4];
    logic       chg_seq [4];

    initial begin
        // Reset with random inputs
        rst_n = 1'b0; en = 1'b1; cnt_clr = 1'b0;
        r = 6'($urandom_range(0, 63));
        {a, b, c, d, sel} = r;
        tick();
        r = 6'($urandom_range(0, 63));
        {a, b, c, d, sel} = r;
        tick();
        chk("rst_y", 32'(y1), 32'd0);
        chk("rst_selq", 32'(sel_q1), 32'd0);
        chk("rst_chg", 32'(chg1), 32'd0);
        chk("rst_cnt", 32'({ca1, cb1, cc1, cd1}), 32'd0);
        rst_n = 1'b1;

        // One capture per select
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0; en = 1'b1;
        sel_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
        y_seq   = '{1'b1, 1'b0, 1'b1, 1'b0};
        chg_seq = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            sel = sel_seq[i];
            tick();
            chk($sformatf("sel%0d_y", i), 32'(y1), 32'(y_seq[i]));
            chk($sformatf("sel%0d_chg", i), 32'(chg1), 32'(chg_seq[i]));
            chk($sformatf("sel%0d_selq", i), 32'(sel_q1), 32'(sel_seq[i]));
        end
        chk("each_cnt", 32'({ca1, cb1, cc1, cd1}), 32'h01010101);

        // Data moving between edges does not reach y
        #1 d = 1'b1;
        #1 chk("no_edge_y", 32'(y1), 32'd0);
        d = 1'b0;

        // Hold with en low
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            {a, b, c, d} = 4'(4'hF - i);
            tick();
            chk($sformatf("hold%0d_y", i), 32'(y1), 32'd0);
            chk($sformatf("hold%0d_selq", i), 32'(sel_q1), 32'd3);
            chk($sformatf("hold%0d_chg", i), 32'(chg1), 32'd0);
            chk($sformatf("hold%0d_cnt", i), 32'({ca1, cb1, cc1, cd1}), 32'h01010101);
        end

        // Clear counters before the random run
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'({ca1, cb1, cc1, cd1}), 32'd0);
        chk("clr_selq", 32'(sel_q1), 32'd3);

        // Random vectors against a reference mux
        en = 1'b1;
        exp_selq = 2'b11;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        for (int i = 0; i < 10; i++) begin
            r = 6'($urandom_range(0, 63));
            {a, b, c, d, sel} = r;
            abcd = r[5:2];
            exp_y = abcd[3 - int'(r[1:0])];
            tick();
            chk($sformatf("rnd%0d_y", i), 32'(y1), 32'(exp_y));
            chk($sformatf("rnd%0d_chg", i), 32'(chg1), 32'(r[1:0] != exp_selq));
            exp_selq = r[1:0];
            exp_cnt[r[1:0]]++;
        end
        chk("rnd_cnt_a", 32'(ca1), 32'(exp_cnt[0]));
        chk("rnd_cnt_b", 32'(cb1), 32'(exp_cnt[1]));
        chk("rnd_cnt_c", 32'(cc1), 32'(exp_cnt[2]));
        chk("rnd_cnt_d", 32'(cd1), 32'(exp_cnt[3]));
        sum = int'(ca1) + int'(cb1) + int'(cc1) + int'(cd1);
        chk("rnd_cnt_sum", 32'(sum), 32'd10);

        // Saturation on the 2-bit counter instance
        en = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; en = 1'b1;
        sel = 2'b00; a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat%0d_cnt_a", i), 32'(ca2), 32'((i > 3) ? 3 : i));
        end
        chk("sat_wide_cnt_a", 32'(ca1), 32'd5);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_prio_sat", 32'(ca2), 32'd0);
        chk("clr_prio_wide", 32'(ca1), 32'd0);
        chk("clr_keeps_y", 32'(y2), 32'd1);

        // Asynchronous reset between edges
        tick();
        chk("pre_rst_y", 32'(y1), 32'd1);
        chk("pre_rst_cnt", 32'(ca1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_y", 32'(y1), 32'd0);
        chk("async_cnt", 32'(ca1), 32'd0);
        chk("async_selq", 32'({sel_q1, chg1}), 32'd0);
        rst_n = 1'b1;
        sel = 2'b10; c = 1'b1;
        tick();
        chk("post_rst_y", 32'(y1), 32'd1);
        chk("post_rst_chg", 32'(chg1), 32'd1);
        chk("post_rst_cnt_c", 32'(cc1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
